// File: rtl/load_store_unit_pkg.sv
// Shared types for the load/store unit: access size codes, FSM states,
// the latched request record and the alignment rule.
package load_store_unit_pkg;

   typedef enum logic [1:0] {
      SIZE_BYTE = 2'b00,
      SIZE_HALF = 2'b01,
      SIZE_WORD = 2'b10,
      SIZE_ILL  = 2'b11
   } size_e;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_LD_RD   = 3'd1,
      S_LD_RESP = 3'd2,
      S_ST_WR   = 3'd3,
      S_RMW_RD  = 3'd4,
      S_RMW_WR  = 3'd5
   } state_e;

   typedef struct packed {
      logic        write;
      size_e       size;
      logic        sign_ext;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [4:0]  rd;
   } req_t;

   // Illegal size code is reported exactly like a misaligned access.
   function automatic logic is_aligned(input size_e size, input logic [1:0] off);
      logic ok;
      case (size)
         SIZE_BYTE: ok = 1'b1;
         SIZE_HALF: ok = ~off[0];
         SIZE_WORD: ok = (off == 2'b00);
         default:   ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/load_store_unit_lane_align.sv
// Big-endian byte-lane steering: load extraction with sign/zero extension,
// and store merge of a sub-word into a read word.
module lsu_lane_align
   import load_store_unit_pkg::*;
(
   input  logic [31:0] word_i,
   input  logic [1:0]  offset_i,
   input  size_e       size_i,
   input  logic        signed_i,
   input  logic [31:0] store_data_i,
   output logic [31:0] load_value_o,
   output logic [31:0] merged_word_o
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = '0;
      case (offset_i)
         2'd0:    byte_sel = word_i[31:24];
         2'd1:    byte_sel = word_i[23:16];
         2'd2:    byte_sel = word_i[15:8];
         default: byte_sel = word_i[7:0];
      endcase
      half_sel = offset_i[1] ? word_i[15:0] : word_i[31:16];

      load_value_o = word_i;
      case (size_i)
         SIZE_BYTE: load_value_o = {{24{signed_i & byte_sel[7]}}, byte_sel};
         SIZE_HALF: load_value_o = {{16{signed_i & half_sel[15]}}, half_sel};
         default:   load_value_o = word_i;
      endcase
   end

   always_comb begin
      merged_word_o = word_i;
      case (size_i)
         SIZE_BYTE: begin
            case (offset_i)
               2'd0:    merged_word_o[31:24] = store_data_i[7:0];
               2'd1:    merged_word_o[23:16] = store_data_i[7:0];
               2'd2:    merged_word_o[15:8]  = store_data_i[7:0];
               default: merged_word_o[7:0]   = store_data_i[7:0];
            endcase
         end
         SIZE_HALF: begin
            if (offset_i[1]) merged_word_o[15:0]  = store_data_i[15:0];
            else             merged_word_o[31:16] = store_data_i[15:0];
         end
         SIZE_WORD: merged_word_o = store_data_i;
         default:   merged_word_o = word_i;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit: request latch and access FSM driving a
// single-cycle word memory; sub-word stores use read-modify-write.
module load_store_unit
   import load_store_unit_pkg::*;
(
   input  logic        CLK,
   input  logic        RST_N,
   input  logic        ReqValid,
   input  logic        ReqWrite,
   input  logic [1:0]  ReqSize,
   input  logic        ReqSigned,
   input  logic [31:0] ReqAddr,
   input  logic [31:0] ReqWData,
   input  logic [4:0]  ReqRd,
   output logic        StallM,
   output logic        LoadValid,
   output logic [31:0] LoadData,
   output logic [4:0]  LoadRd,
   output logic        MisalignErr,
   output logic [31:0] MemA,
   output logic [31:0] MemWD,
   output logic        MemWE,
   input  logic [31:0] MemRD
);

   state_e state_q, state_d;
   req_t   req_q, req_d;

   size_e       req_size_in;
   logic        req_aligned;
   logic [31:0] load_value;
   logic [31:0] merged_word;

   assign req_size_in = size_e'(ReqSize);
   assign req_aligned = is_aligned(req_size_in, ReqAddr[1:0]);

   lsu_lane_align u_lane_align (
      .word_i        (MemRD),
      .offset_i      (req_q.addr[1:0]),
      .size_i        (req_q.size),
      .signed_i      (req_q.sign_ext),
      .store_data_i  (req_q.wdata),
      .load_value_o  (load_value),
      .merged_word_o (merged_word)
   );

   always_comb begin
      state_d     = state_q;
      req_d       = req_q;
      StallM      = 1'b0;
      LoadValid   = 1'b0;
      LoadData    = '0;
      LoadRd      = '0;
      MisalignErr = 1'b0;
      MemA        = {req_q.addr[31:2], 2'b00};
      MemWD       = '0;
      MemWE       = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (ReqValid) begin
               if (req_aligned) begin
                  StallM         = 1'b1;
                  req_d.write    = ReqWrite;
                  req_d.size     = req_size_in;
                  req_d.sign_ext = ReqSigned;
                  req_d.addr     = ReqAddr;
                  req_d.wdata    = ReqWData;
                  req_d.rd       = ReqRd;
                  if (!ReqWrite)                    state_d = S_LD_RD;
                  else if (req_size_in == SIZE_WORD) state_d = S_ST_WR;
                  else                              state_d = S_RMW_RD;
               end else begin
                  MisalignErr = 1'b1;
               end
            end
         end
         S_LD_RD: begin
            StallM  = 1'b1;
            state_d = S_LD_RESP;
         end
         S_LD_RESP: begin
            LoadValid = 1'b1;
            LoadData  = load_value;
            LoadRd    = req_q.rd;
            state_d   = S_IDLE;
         end
         S_ST_WR: begin
            MemWE   = 1'b1;
            MemWD   = req_q.wdata;
            state_d = S_IDLE;
         end
         S_RMW_RD: begin
            StallM  = 1'b1;
            state_d = S_RMW_WR;
         end
         S_RMW_WR: begin
            MemWE   = 1'b1;
            MemWD   = merged_word;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state_q <= S_IDLE;
         req_q   <= '0;
      end else begin
         state_q <= state_d;
         req_q   <= req_d;
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed scenarios plus random
// traffic checked against a byte-addressed big-endian memory model.
module tb_load_store_unit;

   logic        CLK = 1'b0;
   logic        RST_N;
   logic        ReqValid, ReqWrite, ReqSigned;
   logic [1:0]  ReqSize;
   logic [31:0] ReqAddr, ReqWData;
   logic [4:0]  ReqRd;
   logic        StallM, LoadValid, MisalignErr, MemWE;
   logic [31:0] LoadData, MemA, MemWD, MemRD;
   logic [4:0]  LoadRd;

   int checks = 0;
   int errors = 0;

   localparam logic [31:0] BASE = 32'h7FFF_FF00;

   // Memory the DUT talks to: 16 words covering BASE..BASE+0x3F.
   logic [31:0] mem_words [0:15];
   // Reference model: independent byte view of the same region.
   logic [7:0]  ref_bytes [0:63];

   load_store_unit dut (
      .CLK(CLK), .RST_N(RST_N),
      .ReqValid(ReqValid), .ReqWrite(ReqWrite), .ReqSize(ReqSize),
      .ReqSigned(ReqSigned), .ReqAddr(ReqAddr), .ReqWData(ReqWData),
      .ReqRd(ReqRd), .StallM(StallM), .LoadValid(LoadValid),
      .LoadData(LoadData), .LoadRd(LoadRd), .MisalignErr(MisalignErr),
      .MemA(MemA), .MemWD(MemWD), .MemWE(MemWE), .MemRD(MemRD)
   );

   always #5 CLK = ~CLK;

   always @(posedge CLK) begin
      MemRD <= mem_words[MemA[5:2]];
      if (MemWE) mem_words[MemA[5:2]] <= MemWD;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
      $fatal(1);
   end

   function automatic int size_bytes(input logic [1:0] sz);
      return (sz == 2'd3) ? 0 : (1 << sz);
   endfunction

   function automatic logic ref_legal(input logic [31:0] a, input logic [1:0] sz);
      int n = size_bytes(sz);
      if (n == 0) return 1'b0;
      return (int'(a[1:0]) % n) == 0;
   endfunction

   function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [1:0] sz, input logic sg);
      int n = size_bytes(sz);
      longint unsigned v = 0;
      for (int i = 0; i < n; i++)
         v = (v << 8) | longint'(ref_bytes[(int'(a[5:0]) + i) & 63]);
      if (sg && n < 4 && ((v >> (8 * n - 1)) & 1) == 1)
         v = v | ~((64'd1 << (8 * n)) - 1);
      return v[31:0];
   endfunction

   task automatic ref_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d);
      int n = size_bytes(sz);
      for (int i = 0; i < n; i++)
         ref_bytes[(int'(a[5:0]) + i) & 63] = 8'((d >> (8 * (n - 1 - i))) & 32'hFF);
   endtask

   function automatic logic [31:0] ref_word(input logic [31:0] a);
      int b = int'(a[5:0]) & 60;
      return {ref_bytes[b], ref_bytes[b+1], ref_bytes[b+2], ref_bytes[b+3]};
   endfunction

   task automatic preload(input logic [31:0] a, input logic [31:0] w);
      mem_words[a[5:2]] = w;
      ref_store({a[31:2], 2'b00}, 2'd2, w);
   endtask

   // Presents one request (called just after a posedge) and observes it
   // until the cycle in which StallM drops; returns what was seen.
   task automatic issue(input logic w, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rd,
                        output int stalls, output int ld_cyc, output logic [31:0] ld_data,
                        output logic [4:0] ld_rd, output logic mis, output int we_cnt,
                        output logic [31:0] we_data, output logic [31:0] we_addr,
                        output logic leak, output logic timeout);
      logic done = 1'b0;
      stalls = 0; ld_cyc = 0; ld_data = '0; ld_rd = '0; mis = 1'b0;
      we_cnt = 0; we_data = '0; we_addr = '0; leak = 1'b0;
      ReqValid = 1'b1; ReqWrite = w; ReqSize = sz; ReqSigned = sg;
      ReqAddr = a; ReqWData = wd; ReqRd = rd;
      for (int c = 1; c <= 8; c++) begin
         @(negedge CLK);
         if (StallM) stalls++;
         if (LoadValid) begin ld_cyc = c; ld_data = LoadData; ld_rd = LoadRd; end
         else if (LoadData !== 32'd0) leak = 1'b1;
         if (MisalignErr) mis = 1'b1;
         if (MemWE) begin we_cnt++; we_data = MemWD; we_addr = MemA; end
         done = !StallM;
         @(posedge CLK); #1;
         if (done) break;
      end
      timeout = !done;
      ReqValid = 1'b0;
   endtask

   task automatic test_reset;
      RST_N = 1'b0; ReqValid = 1'b0; ReqWrite = 1'b0; ReqSize = 2'd0;
      ReqSigned = 1'b0; ReqAddr = '0; ReqWData = '0; ReqRd = '0;
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      checks++;
      if ({StallM, LoadValid, MisalignErr, MemWE, LoadRd, LoadData, MemA, MemWD} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: stall=%0b lv=%0b mis=%0b we=%0b rd=%0d ld=%h a=%h wd=%h, required all 0",
                  StallM, LoadValid, MisalignErr, MemWE, LoadRd, LoadData, MemA, MemWD);
      end
      @(posedge CLK); #1;
      RST_N = 1'b1;
   endtask

   task automatic test_loads;
      int st, lc, we; logic [31:0] ld, wdv, wa; logic [4:0] lr; logic m, lk, to;
      logic [31:0] addrs [3] = '{BASE + 1, BASE + 3, BASE + 2};
      logic [1:0]  sizes [3] = '{2'd0, 2'd0, 2'd1};
      logic        sgns  [3] = '{1'b1, 1'b0, 1'b1};
      logic [31:0] exps  [3] = '{32'hFFFF_FF99, 32'h0000_00BB, 32'hFFFF_AABB};
      preload(BASE, 32'h8899_AABB);
      for (int i = 0; i < 3; i++) begin
         issue(1'b0, sizes[i], sgns[i], addrs[i], 32'h0, 5'(i + 3), st, lc, ld, lr, m, we, wdv, wa, lk, to);
         checks++;
         if (to || st != 2 || lc != 3 || ld !== exps[i] || lr !== 5'(i + 3)) begin
            errors++;
            $display("FAIL load_%0d: stalls=%0d lvcyc=%0d data=%h rd=%0d to=%0b, required stalls=2 lvcyc=3 data=%h rd=%0d",
                     i, st, lc, ld, lr, to, exps[i], i + 3);
         end
         checks++;
         if (we != 0 || m || lk) begin
            errors++;
            $display("FAIL load_side_%0d: we=%0d mis=%0b leak=%0b, required 0 0 0", i, we, m, lk);
         end
      end
   endtask

   task automatic test_sub_store;
      int st, lc, we; logic [31:0] ld, wdv, wa; logic [4:0] lr; logic m, lk, to;
      issue(1'b1, 2'd0, 1'b0, BASE + 2, 32'h0000_0011, 5'd0, st, lc, ld, lr, m, we, wdv, wa, lk, to);
      ref_store(BASE + 2, 2'd0, 32'h11);
      checks++;
      if (to || st != 2 || we != 1 || wdv !== 32'h8899_11BB || wa !== BASE) begin
         errors++;
         $display("FAIL sb_rmw: stalls=%0d we=%0d wd=%h a=%h, required 2 1 889911bb %h", st, we, wdv, wa, BASE);
      end
      issue(1'b0, 2'd2, 1'b0, BASE, 32'h0, 5'd9, st, lc, ld, lr, m, we, wdv, wa, lk, to);
      checks++;
      if (to || lc != 3 || ld !== 32'h8899_11BB) begin
         errors++;
         $display("FAIL sb_readback: lvcyc=%0d data=%h, required 3 889911bb", lc, ld);
      end
   endtask

   task automatic test_misalign;
      int st, lc, we; logic [31:0] ld, wdv, wa; logic [4:0] lr; logic m, lk, to;
      logic [31:0] addrs [3] = '{BASE + 2, BASE + 1, BASE};
      logic [1:0]  sizes [3] = '{2'd2, 2'd1, 2'd3};
      logic        wrs   [3] = '{1'b0, 1'b1, 1'b1};
      for (int i = 0; i < 3; i++) begin
         issue(wrs[i], sizes[i], 1'b0, addrs[i], 32'hFFFF_FFFF, 5'd1, st, lc, ld, lr, m, we, wdv, wa, lk, to);
         checks++;
         if (to || !m || st != 0 || we != 0 || lc != 0) begin
            errors++;
            $display("FAIL misalign_%0d: mis=%0b stalls=%0d we=%0d lvcyc=%0d to=%0b, required 1 0 0 0 0",
                     i, m, st, we, lc, to);
         end
      end
      issue(1'b0, 2'd2, 1'b0, BASE, 32'h0, 5'd4, st, lc, ld, lr, m, we, wdv, wa, lk, to);
      checks++;
      if (to || st != 2 || lc != 3 || ld !== ref_load(BASE, 2'd2, 1'b0)) begin
         errors++;
         $display("FAIL misalign_then_load: stalls=%0d lvcyc=%0d data=%h, required 2 3 %h",
                  st, lc, ld, ref_load(BASE, 2'd2, 1'b0));
      end
   endtask

   task automatic test_reset_rmw;
      int st, lc, we; logic [31:0] ld, wdv, wa; logic [4:0] lr; logic m, lk, to;
      issue(1'b1, 2'd2, 1'b0, BASE, 32'h8899_AABB, 5'd0, st, lc, ld, lr, m, we, wdv, wa, lk, to);
      ref_store(BASE, 2'd2, 32'h8899_AABB);
      ReqValid = 1'b1; ReqWrite = 1'b1; ReqSize = 2'd1; ReqSigned = 1'b0;
      ReqAddr = BASE; ReqWData = 32'h0000_CAFE; ReqRd = '0;
      @(negedge CLK);
      checks++;
      if (StallM !== 1'b1 || MemWE !== 1'b0) begin
         errors++;
         $display("FAIL rst_rmw_accept: stall=%0b we=%0b, required 1 0", StallM, MemWE);
      end
      @(posedge CLK); #1;
      RST_N = 1'b0; ReqValid = 1'b0;
      @(negedge CLK);
      checks++;
      if (StallM !== 1'b1 || MemWE !== 1'b0) begin
         errors++;
         $display("FAIL rst_rmw_rd: stall=%0b we=%0b, required 1 0", StallM, MemWE);
      end
      @(posedge CLK); #1;
      RST_N = 1'b1;
      @(negedge CLK);
      checks++;
      if ({StallM, LoadValid, MisalignErr, MemWE, LoadRd, LoadData, MemA, MemWD} !== '0) begin
         errors++;
         $display("FAIL rst_rmw_outputs: stall=%0b lv=%0b mis=%0b we=%0b rd=%0d ld=%h a=%h wd=%h, required all 0",
                  StallM, LoadValid, MisalignErr, MemWE, LoadRd, LoadData, MemA, MemWD);
      end
      @(posedge CLK); #1;
      checks++;
      if (mem_words[0] !== 32'h8899_AABB) begin
         errors++;
         $display("FAIL rst_rmw_mem: word=%h, required 8899aabb", mem_words[0]);
      end
      issue(1'b0, 2'd2, 1'b0, BASE, 32'h0, 5'd2, st, lc, ld, lr, m, we, wdv, wa, lk, to);
      checks++;
      if (to || ld !== 32'h8899_AABB) begin
         errors++;
         $display("FAIL rst_rmw_readback: data=%h, required 8899aabb", ld);
      end
   endtask

   task automatic test_back_to_back;
      int st, lc, we; logic [31:0] ld, wdv, wa; logic [4:0] lr; logic m, lk, to;
      int st2, lc2, we2; logic [31:0] ld2, wdv2, wa2; logic [4:0] lr2; logic m2, lk2, to2;
      issue(1'b1, 2'd2, 1'b0, BASE + 8, 32'hDEAD_BEEF, 5'd0, st, lc, ld, lr, m, we, wdv, wa, lk, to);
      ref_store(BASE + 8, 2'd2, 32'hDEAD_BEEF);
      issue(1'b0, 2'd2, 1'b0, BASE + 8, 32'h0, 5'd17, st2, lc2, ld2, lr2, m2, we2, wdv2, wa2, lk2, to2);
      checks++;
      if (to || st != 1 || we != 1 || wdv !== 32'hDEAD_BEEF || wa !== BASE + 8) begin
         errors++;
         $display("FAIL b2b_sw: stalls=%0d we=%0d wd=%h a=%h, required 1 1 deadbeef %h", st, we, wdv, wa, BASE + 8);
      end
      checks++;
      if (to2 || st2 != 2 || lc2 != 3 || ld2 !== 32'hDEAD_BEEF || lr2 !== 5'd17) begin
         errors++;
         $display("FAIL b2b_lw: stalls=%0d lvcyc=%0d data=%h rd=%0d, required 2 3 deadbeef 17", st2, lc2, ld2, lr2);
      end
   endtask

   task automatic test_random;
      int st, lc, we; logic [31:0] ld, wdv, wa; logic [4:0] lr; logic m, lk, to;
      for (int i = 0; i < 300; i++) begin
         logic [31:0] a  = BASE | 32'($urandom_range(0, 63));
         int          r  = $urandom_range(0, 9);
         logic [1:0]  sz = (r == 9) ? 2'd3 : 2'(r / 3);
         logic        w  = 1'($urandom_range(0, 1));
         logic        sg = 1'($urandom_range(0, 1));
         logic [31:0] d  = $urandom;
         logic [4:0]  rd = 5'($urandom_range(0, 31));
         if ($urandom_range(0, 3) == 0) begin
            @(negedge CLK);
            checks++;
            if (StallM !== 1'b0 || MemWE !== 1'b0 || MisalignErr !== 1'b0) begin
               errors++;
               $display("FAIL rand_idle: stall=%0b we=%0b mis=%0b, required 0 0 0", StallM, MemWE, MisalignErr);
            end
            @(posedge CLK); #1;
         end
         issue(w, sz, sg, a, d, rd, st, lc, ld, lr, m, we, wdv, wa, lk, to);
         checks++;
         if (to || lk) begin
            errors++;
            $display("FAIL rand_%0d_hang_leak: timeout=%0b leak=%0b, required 0 0", i, to, lk);
         end else if (!ref_legal(a, sz)) begin
            if (!m || st != 0 || we != 0 || lc != 0) begin
               errors++;
               $display("FAIL rand_%0d_misalign: a=%h sz=%0d mis=%0b stalls=%0d we=%0d, required 1 0 0", i, a, sz, m, st, we);
            end
         end else if (!w) begin
            if (m || st != 2 || lc != 3 || we != 0 || ld !== ref_load(a, sz, sg) || lr !== rd) begin
               errors++;
               $display("FAIL rand_%0d_load: a=%h sz=%0d sg=%0b data=%h rd=%0d stalls=%0d lvcyc=%0d, required data=%h rd=%0d stalls=2 lvcyc=3",
                        i, a, sz, sg, ld, lr, st, lc, ref_load(a, sz, sg), rd);
            end
         end else begin
            ref_store(a, sz, d);
            if (m || st != ((sz == 2'd2) ? 1 : 2) || we != 1 || wdv !== ref_word(a) || wa !== {a[31:2], 2'b00}) begin
               errors++;
               $display("FAIL rand_%0d_store: a=%h sz=%0d wd=%h wa=%h we=%0d stalls=%0d, required wd=%h wa=%h we=1",
                        i, a, sz, wdv, wa, we, st, ref_word(a), {a[31:2], 2'b00});
            end
         end
      end
   endtask

   initial begin
      for (int i = 0; i < 16; i++) preload(BASE + 32'(4 * i), $urandom);
      test_reset;
      test_loads;
      test_sub_store;
      test_misalign;
      test_reset_rmw;
      test_back_to_back;
      test_random;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
